// File: rtl/conv_pkg.sv
// Shared conv2d constants and the write-back FSM state encoding.
package conv_pkg;

    localparam int CONV_OCH    = 4;
    localparam int CONV_HEIGHT = 28;
    localparam int CONV_WIDTH  = 28;

    typedef logic [2:0] state_t;

    localparam state_t IDLE  = 3'd0;
    localparam state_t LOAD  = 3'd1;
    localparam state_t RUN   = 3'd2;
    localparam state_t FLUSH = 3'd3;
    localparam state_t DONE  = 3'd4;

    // Counter width that stays legal for degenerate sizes of 1.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/out_requant.sv
// Requantises one accumulator: bias add, arithmetic shift, optional ReLU, saturate.
module out_requant #(
    parameter int ACC_W   = 32,
    parameter int BIAS_W  = 16,
    parameter int OUT_W   = 16,
    parameter int SHIFT   = 0,
    parameter int RELU_EN = 1
) (
    input  logic signed [ACC_W-1:0]  in_sum,
    input  logic signed [BIAS_W-1:0] bias,
    output logic        [OUT_W-1:0]  result
);

    localparam logic signed [ACC_W:0] MAX_V = {{(ACC_W+2-OUT_W){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] MIN_V = {{(ACC_W+2-OUT_W){1'b1}}, {(OUT_W-1){1'b0}}};

    logic signed [ACC_W:0] sum;
    logic signed [ACC_W:0] shifted;
    logic signed [ACC_W:0] clipped;

    // NOTE: every path assigns result, so no latch can be inferred here.
    always_comb begin
        sum     = {in_sum[ACC_W-1], in_sum} + {{(ACC_W+1-BIAS_W){bias[BIAS_W-1]}}, bias};
        shifted = sum >>> SHIFT;
        clipped = (RELU_EN != 0 && shifted[ACC_W]) ? '0 : shifted;
        if (clipped > MAX_V)
            result = MAX_V[OUT_W-1:0];
        else if (clipped < MIN_V)
            result = MIN_V[OUT_W-1:0];
        else
            result = clipped[OUT_W-1:0];
    end

endmodule

// File: rtl/conv_out_writer.sv
// conv2d write-back: preloads biases, requantises each accumulated pixel sum and
// writes it to the output buffer in och > h > w order.
module conv_out_writer
    import conv_pkg::*;
#(
    parameter int OCH     = CONV_OCH,
    parameter int HEIGHT  = CONV_HEIGHT,
    parameter int WIDTH   = CONV_WIDTH,
    parameter int ACC_W   = 32,
    parameter int BIAS_W  = 16,
    parameter int OUT_W   = 16,
    parameter int SHIFT   = 0,
    parameter int RELU_EN = 1,
    parameter int ADDR_W  = 12
) (
    input  logic                 clk,
    input  logic                 xrst,
    input  logic                 start,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [ACC_W-1:0]     in_sum,
    output logic                 bias_rd_en,
    output logic [cnt_w(OCH)-1:0] bias_rd_addr,
    input  logic [BIAS_W-1:0]    bias_rd_data,
    output logic                 wr_en,
    output logic [ADDR_W-1:0]    wr_addr,
    output logic [OUT_W-1:0]     wr_data,
    input  logic                 wr_ready,
    output logic                 busy,
    output logic                 done
);

    localparam int OCH_W = cnt_w(OCH);
    localparam int H_W   = cnt_w(HEIGHT);
    localparam int W_W   = cnt_w(WIDTH);
    localparam int K_W   = cnt_w(OCH + 1);

    localparam logic [OCH_W-1:0] OCH_LAST = OCH_W'(OCH - 1);
    localparam logic [H_W-1:0]   H_LAST   = H_W'(HEIGHT - 1);
    localparam logic [W_W-1:0]   W_LAST   = W_W'(WIDTH - 1);
    localparam logic [K_W-1:0]   K_END    = K_W'(OCH);

    state_t              state;
    logic [K_W-1:0]      k;
    logic [BIAS_W-1:0]   breg [OCH];
    logic [OCH_W-1:0]    och;
    logic [H_W-1:0]      h;
    logic [W_W-1:0]      w;
    logic [ADDR_W-1:0]   addr;
    logic [OUT_W-1:0]    result;
    logic                accept;
    logic                last_beat;

    assign busy         = (state != IDLE);
    assign done         = (state == DONE);
    assign in_ready     = (state == RUN) && (!wr_en || wr_ready);
    assign accept       = in_valid && in_ready;
    assign last_beat    = (och == OCH_LAST) && (h == H_LAST) && (w == W_LAST);
    assign bias_rd_en   = (state == LOAD) && (k != K_END);
    assign bias_rd_addr = bias_rd_en ? k[OCH_W-1:0] : '0;

    out_requant #(
        .ACC_W  (ACC_W),
        .BIAS_W (BIAS_W),
        .OUT_W  (OUT_W),
        .SHIFT  (SHIFT),
        .RELU_EN(RELU_EN)
    ) u_requant (
        .in_sum (in_sum),
        .bias   (breg[och]),
        .result (result)
    );

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            state   <= IDLE;
            k       <= '0;
            och     <= '0;
            h       <= '0;
            w       <= '0;
            addr    <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            // NOTE: the bias file is only OCH words of flops, so it is reset rather than left as RAM.
            for (int i = 0; i < OCH; i++) breg[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= LOAD;
                        k     <= '0;
                    end
                end
                LOAD: begin
                    // RAM data lags the address by one cycle; shift it in from the top.
                    k <= k + 1'b1;
                    if (k != '0) begin
                        for (int i = 0; i < OCH - 1; i++) breg[i] <= breg[i+1];
                        breg[OCH-1] <= bias_rd_data;
                    end
                    if (k == K_END) state <= RUN;
                end
                RUN: begin
                    if (accept) begin
                        wr_data <= result;
                        wr_addr <= addr;
                        wr_en   <= 1'b1;
                        addr    <= addr + 1'b1;
                        if (w == W_LAST) begin
                            w <= '0;
                            if (h == H_LAST) begin
                                h   <= '0;
                                och <= (och == OCH_LAST) ? '0 : och + 1'b1;
                            end else begin
                                h <= h + 1'b1;
                            end
                        end else begin
                            w <= w + 1'b1;
                        end
                        if (last_beat) state <= FLUSH;
                    end else if (wr_en && wr_ready) begin
                        wr_en <= 1'b0;
                    end
                end
                FLUSH: begin
                    if (!wr_en || wr_ready) begin
                        wr_en <= 1'b0;
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    k     <= '0;
                    och   <= '0;
                    h     <= '0;
                    w     <= '0;
                    addr  <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_out_writer.sv
// Directed bench for conv_out_writer: a default-size instance with ReLU and a
// small RELU_EN=0 instance for the negative saturation cases.
module tb_conv_out_writer;

    localparam int NBEAT  = 3136;
    localparam int PIX    = 784;
    localparam int BUDGET = 6000;

    typedef struct {
        int beat;
        int sum;
        int exp_data;
    } vec_t;

    logic clk  = 1'b0;
    logic xrst = 1'b0;

    logic        start_a = 1'b0, in_valid_a = 1'b0, wr_ready_a = 1'b0;
    logic [31:0] in_sum_a = '0;
    logic        in_ready_a, bias_rd_en_a, wr_en_a, busy_a, done_a;
    logic [1:0]  bias_rd_addr_a;
    logic [15:0] bias_rd_data_a = '0;
    logic [11:0] wr_addr_a;
    logic [15:0] wr_data_a;

    logic        start_b = 1'b0, in_valid_b = 1'b0, wr_ready_b = 1'b0;
    logic [31:0] in_sum_b = '0;
    logic        in_ready_b, bias_rd_en_b, wr_en_b, busy_b, done_b;
    logic [0:0]  bias_rd_addr_b;
    logic [15:0] bias_rd_data_b = '0;
    logic [2:0]  wr_addr_b;
    logic [15:0] wr_data_b;

    int checks = 0;
    int errors = 0;
    int bias_a [4] = '{10, -5, 0, 7};
    int bias_b [2] = '{3, -2};
    vec_t spec_tab  [11];
    vec_t arith_tab [8];

    int write_cnt, done_cnt, last_wr_cyc, done_cyc, exp_addr;

    always #5 clk = ~clk;

    conv_out_writer dut_a (
        .clk(clk), .xrst(xrst), .start(start_a),
        .in_valid(in_valid_a), .in_ready(in_ready_a), .in_sum(in_sum_a),
        .bias_rd_en(bias_rd_en_a), .bias_rd_addr(bias_rd_addr_a), .bias_rd_data(bias_rd_data_a),
        .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a), .wr_ready(wr_ready_a),
        .busy(busy_a), .done(done_a)
    );

    conv_out_writer #(.OCH(2), .HEIGHT(2), .WIDTH(2), .RELU_EN(0), .ADDR_W(3)) dut_b (
        .clk(clk), .xrst(xrst), .start(start_b),
        .in_valid(in_valid_b), .in_ready(in_ready_b), .in_sum(in_sum_b),
        .bias_rd_en(bias_rd_en_b), .bias_rd_addr(bias_rd_addr_b), .bias_rd_data(bias_rd_data_b),
        .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b), .wr_ready(wr_ready_b),
        .busy(busy_b), .done(done_b)
    );

    // Synchronous bias RAMs: data one cycle after the read enable.
    always_ff @(posedge clk) begin
        if (bias_rd_en_a) bias_rd_data_a <= 16'(bias_a[bias_rd_addr_a]);
        if (bias_rd_en_b) bias_rd_data_b <= 16'(bias_b[bias_rd_addr_b]);
    end

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic reset_check(input string tag);
        check({tag, "_wr_en"},   longint'(wr_en_a), 0);
        check({tag, "_wr_addr"}, longint'(wr_addr_a), 0);
        check({tag, "_wr_data"}, longint'(wr_data_a), 0);
        check({tag, "_busy"},    longint'(busy_a), 0);
        check({tag, "_done"},    longint'(done_a), 0);
        check({tag, "_ready"},   longint'(in_ready_a), 0);
        check({tag, "_rd_en"},   longint'(bias_rd_en_a), 0);
    endtask

    function automatic int sum_for(input int b);
        foreach (spec_tab[i]) if (spec_tab[i].beat == b) return spec_tab[i].sum;
        return b;
    endfunction

    function automatic int exp_for(input int a);
        if (a < 0 || a >= NBEAT) return -1;
        foreach (spec_tab[i]) if (spec_tab[i].beat == a) return spec_tab[i].exp_data;
        return a + bias_a[a / PIX];
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Default instance, biases {10,-5,0,7}; default beats expect beat+bias.
        spec_tab[0]  = '{0,    -20,    0};
        spec_tab[1]  = '{1,    40000,  32767};
        spec_tab[2]  = '{2,    -40000, 0};
        spec_tab[3]  = '{783,  5,      15};
        spec_tab[4]  = '{784,  100,    95};
        spec_tab[5]  = '{785,  2,      0};
        spec_tab[6]  = '{1568, 1234,   1234};
        spec_tab[7]  = '{2352, 40000,  32767};
        spec_tab[8]  = '{2353, -20,    0};
        spec_tab[9]  = '{2354, 32760,  32767};
        spec_tab[10] = '{2355, 32761,  32767};
        // Small instance, no ReLU, biases {3,-2}, 4 beats per channel.
        arith_tab[0] = '{0, -40000, -32768};
        arith_tab[1] = '{1, -20,    -17};
        arith_tab[2] = '{2, 40000,  32767};
        arith_tab[3] = '{3, 5,      8};
        arith_tab[4] = '{4, -40000, -32768};
        arith_tab[5] = '{5, 0,      -2};
        arith_tab[6] = '{6, 32769,  32767};
        arith_tab[7] = '{7, -32766, -32768};

        repeat (3) @(negedge clk);
        reset_check("por");
        xrst = 1'b1;
        @(negedge clk);

        // Bias load: start sampled at edge 0, RUN visible in cycle 6.
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            check($sformatf("load_rd_en_c%0d", c), longint'(bias_rd_en_a), (c <= 4) ? 1 : 0);
            if (c <= 4) check($sformatf("load_rd_addr_c%0d", c), longint'(bias_rd_addr_a), c - 1);
            check($sformatf("load_ready_c%0d", c), longint'(in_ready_a), (c == 6) ? 1 : 0);
            check($sformatf("load_busy_c%0d", c), longint'(busy_a), 1);
            if (c < 6) @(negedge clk);
        end
        for (int i = 0; i < 4; i++)
            check($sformatf("breg_%0d", i), longint'($signed(dut_a.breg[i])), bias_a[i]);

        // A few beats, then reset with a write still pending.
        wr_ready_a = 1'b1;
        in_valid_a = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_sum_a = 32'(i + 1);
            @(negedge clk);
        end
        in_valid_a = 1'b0;
        wr_ready_a = 1'b0;
        check("pre_rst_wr_en",   longint'(wr_en_a), 1);
        check("pre_rst_wr_addr", longint'(wr_addr_a), 2);
        check("pre_rst_wr_data", longint'($signed(wr_data_a)), 13);
        xrst = 1'b0;
        #1;
        reset_check("mid_rst");
        check("mid_rst_breg0", longint'($signed(dut_a.breg[0])), 0);
        @(negedge clk);
        xrst = 1'b1;
        @(negedge clk);

        // Full frame with a mid-row stall, a stray start and a stalled flush.
        wr_ready_a = 1'b1;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        for (int n = 0; n < 20 && !in_ready_a; n++) @(negedge clk);
        check("run_entry", longint'(in_ready_a), 1);
        in_valid_a = 1'b1;
        in_sum_a   = 32'(sum_for(0));
        write_cnt = 0; done_cnt = 0; last_wr_cyc = -1; done_cyc = -1; exp_addr = 0;
        fork
            begin : driver
                int beat, cyc;
                bit acc;
                beat = 0;
                cyc  = 0;
                while (beat < NBEAT && cyc < BUDGET) begin
                    acc = in_valid_a && in_ready_a;
                    @(posedge clk);
                    #1;
                    cyc++;
                    if (acc) begin
                        beat++;
                        if (beat < NBEAT) in_sum_a = 32'(sum_for(beat));
                        else in_valid_a = 1'b0;
                    end
                    wr_ready_a = !(cyc >= 40 && cyc < 43) && (beat != NBEAT);
                    start_a    = (cyc == 100);
                    @(negedge clk);
                    if (cyc == 101) begin
                        check("start_ignored_ready", longint'(in_ready_a), 1);
                        check("start_ignored_busy",  longint'(busy_a), 1);
                    end
                end
                check("beats_accepted", beat, NBEAT);
                @(posedge clk);
                #1;
                wr_ready_a = 1'b1;
            end
            begin : monitor
                int mc;
                bit hold;
                logic [11:0] h_addr;
                logic [15:0] h_data;
                mc = 0;
                hold = 1'b0;
                h_addr = '0;
                h_data = '0;
                while (mc < BUDGET && !(done_cnt > 0 && mc > done_cyc + 2)) begin
                    @(negedge clk);
                    mc++;
                    if (hold) begin
                        check("bp_wr_en_held", longint'(wr_en_a), 1);
                        check("bp_addr_stable", longint'(wr_addr_a), longint'(h_addr));
                        check("bp_data_stable", longint'(wr_data_a), longint'(h_data));
                    end
                    hold   = wr_en_a && !wr_ready_a;
                    h_addr = wr_addr_a;
                    h_data = wr_data_a;
                    if (hold) check("bp_in_ready", longint'(in_ready_a), 0);
                    if (wr_en_a && wr_ready_a) begin
                        check($sformatf("wr_addr_%0d", exp_addr), longint'(wr_addr_a), exp_addr);
                        check($sformatf("wr_data_%0d", exp_addr), longint'($signed(wr_data_a)),
                              exp_for(exp_addr));
                        exp_addr++;
                        write_cnt++;
                        last_wr_cyc = mc;
                    end
                    if (done_a) begin
                        done_cnt++;
                        done_cyc = mc;
                    end
                end
            end
        join
        check("frame_writes", write_cnt, NBEAT);
        check("frame_done_count", done_cnt, 1);
        check("frame_done_timing", done_cyc, last_wr_cyc + 1);
        check("frame_idle_busy", longint'(busy_a), 0);
        check("frame_idle_ready", longint'(in_ready_a), 0);

        // Saturation without ReLU on the small instance.
        wr_ready_b = 1'b1;
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        for (int n = 0; n < 20 && !in_ready_b; n++) @(negedge clk);
        check("b_run_entry", longint'(in_ready_b), 1);
        for (int i = 0; i < 8; i++) begin
            in_valid_b = 1'b1;
            in_sum_b   = 32'(arith_tab[i].sum);
            @(negedge clk);
            check($sformatf("b_wr_en_%0d", i),   longint'(wr_en_b), 1);
            check($sformatf("b_wr_addr_%0d", i), longint'(wr_addr_b), arith_tab[i].beat);
            check($sformatf("b_wr_data_%0d", i), longint'($signed(wr_data_b)), arith_tab[i].exp_data);
        end
        in_valid_b = 1'b0;
        check("b_flush_ready", longint'(in_ready_b), 0);
        @(negedge clk);
        check("b_done", longint'(done_b), 1);
        @(negedge clk);
        check("b_done_pulse", longint'(done_b), 0);
        check("b_idle", longint'(busy_b), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
